// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, constants and round-robin pick for the FIFO arbiters
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int PKT_CNT_W = 16;
  localparam int MAX_PORTS = 8;

  // First valid requester at or after ptr, wrapping at n; returns one-hot (or 0 if none valid)
  function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] valid,
                                                   input logic [2:0] ptr,
                                                   input int n);
    logic [MAX_PORTS-1:0] pick;
    logic                 found;
    int                   idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < MAX_PORTS; off++) begin
      idx = (int'(ptr) + off) % n;
      if (off < n && !found && valid[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - per-port ingress beat handshake bundle
interface fifo_write_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
  logic [NUM_PORTS-1:0]            req_eop;
  logic [NUM_PORTS-1:0]            req_ready;

  modport master (output req_valid, output req_data, output req_eop, input req_ready);
  modport slave  (input req_valid, input req_data, input req_eop, output req_ready);

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick with a pointer that advances past the finishing owner
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_PORTS-1:0] valid_i,
  input  logic                 advance_i,
  input  logic [2:0]           owner_idx_i,
  output logic [NUM_PORTS-1:0] pick_o
);

  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [MAX_PORTS-1:0] valid_ext;
  logic [MAX_PORTS-1:0] pick_ext;

  wire unused_ok = &{1'b0, pick_ext};

  // Widen the request vector to the function's fixed width and pick the next owner
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_PORTS-1:0] = valid_i;
    pick_ext                 = rr_pick(valid_ext, rr_ptr_q, NUM_PORTS);
    pick_o                   = pick_ext[NUM_PORTS-1:0];
  end

  // Pointer moves only when a packet completes, to the port after the finishing owner
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i) begin
      rr_ptr_d = (owner_idx_i == 3'(NUM_PORTS - 1)) ? 3'd0 : owner_idx_i + 3'd1;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i) begin
    if (reset_i) rr_ptr_q <= 3'd0;
    else         rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - packet-level round-robin owner of the async FIFO write port
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BIT_SIZE   = 10,
  parameter int MIN_FREE   = 64,
  parameter int GUARD      = 2
) (
  input  logic                  wclk,
  input  logic                  reset,
  fifo_write_arbiter_if.slave   req,
  input  logic                  full,
  input  logic [BIT_SIZE:0]     fifo_occu_in,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [NUM_PORTS-1:0]  grant,
  output logic                  busy,
  output logic [PKT_CNT_W-1:0]  pkt_count
);

  localparam logic [BIT_SIZE:0] DEPTH_V    = {1'b1, {BIT_SIZE{1'b0}}};
  localparam logic [BIT_SIZE:0] MIN_FREE_V = (BIT_SIZE + 1)'(MIN_FREE);
  localparam logic [BIT_SIZE:0] GUARD_V    = (BIT_SIZE + 1)'(GUARD);

  arb_state_t             state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic                   we_q, we_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [PKT_CNT_W-1:0]   pkt_q, pkt_d;

  logic [BIT_SIZE:0]      free;
  logic                   start_ok, beat_ok, advance;
  logic                   own_valid, own_eop;
  logic [DATA_WIDTH-1:0]  own_data;
  logic [2:0]             owner_idx;
  logic [NUM_PORTS-1:0]   pick;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .clk_i       (wclk),
    .reset_i     (reset),
    .valid_i     (req.req_valid),
    .advance_i   (advance),
    .owner_idx_i (owner_idx),
    .pick_o      (pick)
  );

  // Free space; an occupancy beyond depth is treated as no room at all
  always_comb begin
    free = '0;
    if (fifo_occu_in <= DEPTH_V) free = DEPTH_V - fifo_occu_in;
    start_ok = (|req.req_valid) && (free >= MIN_FREE_V) && !full;
    beat_ok  = !full && (free > GUARD_V);
  end

  // Select the current owner's handshake signals from the one-hot grant
  always_comb begin
    own_valid = 1'b0;
    own_eop   = 1'b0;
    own_data  = '0;
    owner_idx = 3'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        own_valid = req.req_valid[i];
        own_eop   = req.req_eop[i];
        own_data  = req.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        owner_idx = 3'(i);
      end
    end
  end

  // Next state: arbitrate in IDLE, stream the owner's beats in XFER until its EOP
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    we_d          = 1'b0;
    wdata_d       = wdata_q;
    pkt_d         = pkt_q;
    advance       = 1'b0;
    req.req_ready = '0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        req.req_ready = grant_q & {NUM_PORTS{beat_ok}};
        if (own_valid && beat_ok) begin
          we_d    = 1'b1;
          wdata_d = own_data;
          if (own_eop) begin
            state_d = IDLE;
            grant_d = '0;
            pkt_d   = pkt_q + 16'd1;
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered FIFO-side outputs
  always_ff @(posedge wclk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      pkt_q   <= pkt_d;
    end
  end

  assign write_enable = we_q;
  assign wdata        = wdata_q;
  assign grant        = grant_q;
  assign busy         = (state_q == XFER);
  assign pkt_count    = pkt_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int BS = 10;

  logic          wclk = 1'b0;
  logic          reset;
  logic          full;
  logic [BS:0]   occ;
  logic          we;
  logic [DW-1:0] wdata;
  logic [NP-1:0] grant;
  logic          busy;
  logic [15:0]   pkt_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [8:0] mem [NP][64];
  int head [NP] = '{default: 0};
  int tail [NP] = '{default: 0};
  int flush_tgt  = 0;
  int flush_seen = 0;
  logic [NP-1:0] acc_mask = '0;

  int obs_d [256];
  int obs_c [256];
  int obs_n = 0;
  int glog [64];
  int glog_n = 0;
  logic [NP-1:0] prev_grant = '0;

  fifo_write_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) rif ();

  fifo_write_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .BIT_SIZE(BS), .MIN_FREE(64), .GUARD(2)
  ) dut (
    .wclk         (wclk),
    .reset        (reset),
    .req          (rif),
    .full         (full),
    .fifo_occu_in (occ),
    .write_enable (we),
    .wdata        (wdata),
    .grant        (grant),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  always #5 wclk = ~wclk;

  always @(posedge wclk) cyc <= cyc + 1;

  // Requester model: pops accepted beats and presents the head of each port queue
  always @(posedge wclk) begin
    logic [NP-1:0]    v, e;
    logic [NP*DW-1:0] d;
    #1;
    if (flush_seen != flush_tgt) begin
      for (int p = 0; p < NP; p++) head[p] = tail[p];
      flush_seen = flush_tgt;
    end
    for (int p = 0; p < NP; p++)
      if (acc_mask[p] && head[p] < tail[p]) head[p]++;
    v = '0; e = '0; d = '0;
    for (int p = 0; p < NP; p++) begin
      if (head[p] < tail[p]) begin
        v[p]           = 1'b1;
        e[p]           = mem[p][head[p]][8];
        d[p*DW +: DW]  = mem[p][head[p]][7:0];
      end
    end
    rif.req_valid = v;
    rif.req_eop   = e;
    rif.req_data  = d;
  end

  // Monitor: handshake, FIFO writes and grant starts, sampled mid-cycle
  always @(negedge wclk) begin
    acc_mask = rif.req_valid & rif.req_ready;
    if (we === 1'b1 && obs_n < 256) begin
      obs_d[obs_n] = int'(wdata);
      obs_c[obs_n] = cyc;
      obs_n++;
    end
    if (grant !== '0 && prev_grant === '0 && glog_n < 64) begin
      for (int p = 0; p < NP; p++) if (grant[p]) glog[glog_n] = p;
      glog_n++;
    end
    prev_grant = grant;
  end

  task automatic tick();
    @(posedge wclk);
    #2;
  endtask

  task automatic enq(input int p, input int n, input int base);
    for (int b = 0; b < n; b++) begin
      mem[p][tail[p]] = {(b == n - 1), 8'(base + b)};
      tail[p]++;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    bit empty;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      empty = 1'b1;
      for (int p = 0; p < NP; p++) if (head[p] < tail[p]) empty = 1'b0;
      if (empty && busy === 1'b0 && we === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    full  = 1'b0;
    occ   = '0;
    flush_tgt++;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; full = 1'b0; occ = '0;
    tick(); tick();
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b exp=0", we); end
    n_cmp++; if (wdata !== 8'h00) begin n_bad++; $display("FAIL reset_wdata got=%h exp=00", wdata); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (pkt_count !== 16'd0) begin n_bad++; $display("FAIL reset_pkt got=%0d exp=0", pkt_count); end
    n_cmp++; if (rif.req_ready !== 4'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0000", rif.req_ready); end
    n_cmp++; if (dut.u_rr.rr_ptr_q !== 3'd0) begin n_bad++; $display("FAIL reset_rr got=%0d exp=0", dut.u_rr.rr_ptr_q); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int s, vcyc;
    bit ok;
    do_reset();
    s = obs_n;
    enq(0, 3, 8'h01);
    tick();
    vcyc = cyc;
    n_cmp++; if (rif.req_valid[0] !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", rif.req_valid[0]); end
    wait_done(30, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout got=0 exp=1"); end
    n_cmp++; if (obs_n - s !== 3) begin n_bad++; $display("FAIL single_nwrites got=%0d exp=3", obs_n - s); end
    n_cmp++; if (obs_c[s] - vcyc !== 2) begin n_bad++; $display("FAIL single_latency got=%0d exp=2", obs_c[s] - vcyc); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs_d[s+i] !== 1 + i || obs_c[s+i] !== obs_c[s] + i) begin
        n_bad++; $display("FAIL single_beat%0d got=%h@%0d exp=%h@%0d", i, obs_d[s+i], obs_c[s+i], 1 + i, obs_c[s] + i);
      end
    end
    n_cmp++; if (pkt_count !== 16'd1) begin n_bad++; $display("FAIL single_pkt got=%0d exp=1", pkt_count); end
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL single_grant got=%b exp=0000", grant); end
  endtask

  task automatic test_two_ports();
    int s, g0;
    int exp_d [4] = '{8'h00, 8'h01, 8'h20, 8'h21};
    int exp_o [4] = '{0, 1, 3, 4};
    bit ok;
    do_reset();
    s = obs_n; g0 = glog_n;
    enq(0, 2, 8'h00);
    enq(2, 2, 8'h20);
    wait_done(30, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL two_timeout got=0 exp=1"); end
    n_cmp++; if (obs_n - s !== 4) begin n_bad++; $display("FAIL two_nwrites got=%0d exp=4", obs_n - s); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_d[s+i] !== exp_d[i] || obs_c[s+i] - obs_c[s] !== exp_o[i]) begin
        n_bad++; $display("FAIL two_beat%0d got=%h@+%0d exp=%h@+%0d", i, obs_d[s+i], obs_c[s+i] - obs_c[s], exp_d[i], exp_o[i]);
      end
    end
    n_cmp++; if (glog[g0] !== 0 || glog[g0+1] !== 2) begin n_bad++; $display("FAIL two_order got=%0d,%0d exp=0,2", glog[g0], glog[g0+1]); end
    n_cmp++; if (dut.u_rr.rr_ptr_q !== 3'd3) begin n_bad++; $display("FAIL two_rr got=%0d exp=3", dut.u_rr.rr_ptr_q); end
  endtask

  task automatic test_round_robin();
    int s, g0;
    bit ok;
    do_reset();
    s = obs_n; g0 = glog_n;
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < NP; p++) enq(p, 1, p * 16 + 8 + k);
    wait_done(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_timeout got=0 exp=1"); end
    n_cmp++; if (glog_n - g0 !== 16) begin n_bad++; $display("FAIL rr_ngrants got=%0d exp=16", glog_n - g0); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (glog[g0+i] !== i % 4 || obs_d[s+i] !== (i % 4) * 16 + 8 + i / 4) begin
        n_bad++; $display("FAIL rr_pkt%0d got=port%0d/%h exp=port%0d/%h", i, glog[g0+i], obs_d[s+i], i % 4, (i % 4) * 16 + 8 + i / 4);
      end
    end
    n_cmp++; if (pkt_count !== 16'd16) begin n_bad++; $display("FAIL rr_pkt got=%0d exp=16", pkt_count); end
  endtask

  task automatic test_low_free();
    int s;
    bit ok;
    do_reset();
    s = obs_n;
    occ = 11'd1000;
    enq(1, 1, 8'h1A);
    repeat (6) tick();
    n_cmp++; if (grant !== 4'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL low_1000 got=%b/%b exp=0000/0", grant, busy); end
    occ = 11'd961;
    repeat (3) tick();
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL low_961 got=%b exp=0000", grant); end
    occ = 11'd1030;
    repeat (3) tick();
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL low_over got=%b exp=0000", grant); end
    n_cmp++; if (obs_n !== s) begin n_bad++; $display("FAIL low_nowrite got=%0d exp=%0d", obs_n, s); end
    occ = 11'd960;
    tick();
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL low_960 got=%b exp=0010", grant); end
    wait_done(20, ok);
    n_cmp++; if (!ok || obs_n - s !== 1 || obs_d[s] !== 8'h1A) begin n_bad++; $display("FAIL low_first got=%0d/%h exp=1/1a", obs_n - s, obs_d[s]); end
    occ = 11'd1000;
    enq(1, 1, 8'h1B);
    repeat (4) tick();
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL low_again got=%b exp=0000", grant); end
    occ = 11'd900;
    tick();
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL low_900 got=%b exp=0010", grant); end
    wait_done(20, ok);
    n_cmp++; if (!ok || obs_d[obs_n-1] !== 8'h1B) begin n_bad++; $display("FAIL low_second got=%h exp=1b", obs_d[obs_n-1]); end
  endtask

  task automatic test_full_stall();
    int s, i;
    bit ok;
    do_reset();
    s = obs_n;
    enq(3, 6, 8'h30);
    i = 0;
    while (obs_n < s + 2 && i < 20) begin tick(); i++; end
    n_cmp++; if (obs_n < s + 2) begin n_bad++; $display("FAIL stall_start got=%0d exp=2", obs_n - s); end
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (rif.req_ready !== 4'b0 || we !== 1'b0 || grant !== 4'b1000) begin
        n_bad++; $display("FAIL stall_full%0d got=rdy%b we%b g%b exp=rdy0000 we0 g1000", k, rif.req_ready, we, grant);
      end
    end
    full = 1'b0;
    occ  = 11'd1022;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (rif.req_ready !== 4'b0 || we !== 1'b0 || grant !== 4'b1000) begin
        n_bad++; $display("FAIL stall_guard%0d got=rdy%b we%b g%b exp=rdy0000 we0 g1000", k, rif.req_ready, we, grant);
      end
    end
    occ = '0;
    wait_done(30, ok);
    n_cmp++; if (!ok || obs_n - s !== 6) begin n_bad++; $display("FAIL stall_count got=%0d exp=6", obs_n - s); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (obs_d[s+k] !== 8'h30 + k) begin n_bad++; $display("FAIL stall_beat%0d got=%h exp=%h", k, obs_d[s+k], 8'h30 + k); end
    end
    n_cmp++; if (pkt_count !== 16'd1) begin n_bad++; $display("FAIL stall_pkt got=%0d exp=1", pkt_count); end
  endtask

  task automatic test_reset_mid();
    int s, g0, i;
    bit ok;
    do_reset();
    enq(1, 1, 8'h1F);
    wait_done(20, ok);
    n_cmp++; if (!ok || pkt_count !== 16'd1) begin n_bad++; $display("FAIL rmid_pre got=%0d exp=1", pkt_count); end
    s = obs_n;
    enq(2, 10, 8'h40);
    i = 0;
    while (obs_n < s + 3 && i < 20) begin tick(); i++; end
    n_cmp++; if (obs_n < s + 3 || busy !== 1'b1) begin n_bad++; $display("FAIL rmid_start got=%0d/%b exp=3/1", obs_n - s, busy); end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 4'b0 || we !== 1'b0 || pkt_count !== 16'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rmid_clear got=g%b we%b pkt%0d busy%b exp=g0000 we0 pkt0 busy0", grant, we, pkt_count, busy);
    end
    flush_tgt++;
    tick();
    reset = 1'b0;
    g0 = glog_n;
    enq(3, 1, 8'h3F);
    enq(0, 1, 8'h0F);
    wait_done(30, ok);
    n_cmp++; if (!ok || glog_n - g0 !== 2) begin n_bad++; $display("FAIL rmid_after got=%0d exp=2", glog_n - g0); end
    n_cmp++; if (glog[g0] !== 0 || glog[g0+1] !== 3) begin n_bad++; $display("FAIL rmid_order got=%0d,%0d exp=0,3", glog[g0], glog[g0+1]); end
  endtask

  initial begin
    reset = 1'b1;
    full  = 1'b0;
    occ   = '0;
    test_reset();
    test_single();
    test_two_ports();
    test_round_robin();
    test_low_free();
    test_full_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of one async FIFO write side among NUM_PORTS ingress requesters in the switch.
- Packet-level round-robin: a grant is held from the first beat to the EOP beat, so packets never interleave in the FIFO.
- Gates writes using the FIFO's registered full flag and write-side occupancy, and drives the FIFO write_enable and data.
- Sits in the wclk domain, directly in front of the FIFO write controller.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- DATA_WIDTH, 8, beat width.
- BIT_SIZE, 10, FIFO address width; depth = 2**BIT_SIZE.
- MIN_FREE, 64, free entries required to start a new packet.
- GUARD, 2, free-entry margin kept mid-packet to cover the one-cycle lag of full and occupancy.

Ports:
- wclk  in  1  write-domain clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port beat valid.
- req_data  in  NUM_PORTS*DATA_WIDTH  per-port beat; port i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_eop  in  NUM_PORTS  marks the last beat of a packet.
- req_ready  out  NUM_PORTS  beat accepted when valid&&ready.
- full  in  1  registered full flag from the FIFO write side.
- fifo_occu_in  in  BIT_SIZE+1  write-side occupancy.
- write_enable  out  1  FIFO write strobe, registered.
- wdata  out  DATA_WIDTH  FIFO write data, registered.
- grant  out  NUM_PORTS  one-hot current owner; 0 when idle.
- busy  out  1  high while in XFER.
- pkt_count  out  16  packets completed, wraps at 2**16.

Behaviour:
- Reset values: state=IDLE, grant=0, req_ready=0, write_enable=0, wdata=0, busy=0, pkt_count=0, rr_ptr=0.
- free = 2**BIT_SIZE − fifo_occu_in, computed at BIT_SIZE+1 bits. fifo_occu_in above depth is treated as free=0.
- IDLE state:
  - If any req_valid and free >= MIN_FREE and !full, pick the first valid port at or after rr_ptr, cyclically.
  - Register that choice in grant and go to XFER next cycle. Arbitration costs one cycle; no beat is accepted in IDLE.
  - Otherwise stay in IDLE.
- XFER state:
  - req_ready[g] = !full && (free > GUARD), combinational. All other req_ready bits are 0.
  - For an accepted beat, write_enable=1 and wdata=req_data[g] on the next edge; latency is 1 cycle.
  - If the port is not valid or not ready, write_enable=0 on the next edge.
  - Accepted beat with req_eop: return to IDLE, set rr_ptr = g+1 mod NUM_PORTS, increment pkt_count, clear grant.
- Throughput: one beat per cycle while ready. A back-to-back packet from another port costs exactly one bubble cycle (the IDLE arbitration cycle).
- A single-beat packet (valid with eop on the first beat) is legal: one write, then IDLE.
- The grant is never revoked mid-packet by full or low occupancy; the owner stalls instead.
- Reset mid-packet: everything returns to reset values on the next edge. A partial packet already in the FIFO is the downstream parser's concern.
- Requesters must hold valid/data/eop stable until accepted. Dropping req_valid mid-packet simply stalls; there is no timeout.
- rr_ptr changes only on EOP acceptance, so a port that loses never starves: it is served within NUM_PORTS−1 packets.

Decomposition:
- Shared package fifo_arb_pkg:
  - State enum arb_state_t {IDLE, XFER}.
  - Function rr_pick(valid, ptr) returning a one-hot grant.
  - Constant PKT_CNT_W=16.
- Natural sub-module: rr_arbiter (combinational pick plus the rr_ptr register), reused later for the read-side egress scheduler.

Test Plan:
- Single port 0 sends a 3-beat packet, FIFO empty → write_enable high 3 cycles, starting 2 cycles after valid (arb + register); pkt_count=1; grant returns to 0.
- Ports 0 and 2 both valid with 2-beat packets, rr_ptr=0 → port 0's packet, one bubble, then port 2's; rr_ptr ends at 3; no interleaving.
- All 4 ports continuously request 1-beat packets for 16 packets → each port granted exactly 4 times, in order 0,1,2,3,0,...
- fifo_occu_in=1000 (free=24 < MIN_FREE=64) with port 1 valid → stays IDLE, no write. Occupancy drops to 900 → grant in the next cycle.
- Mid-packet full=1 for 5 cycles → req_ready[g]=0 and write_enable=0 for those cycles; grant held; transfer resumes with no lost or duplicated beat (compare against a scoreboard).
- reset asserted in the middle of a 10-beat packet → next cycle grant=0, write_enable=0, pkt_count=0; a new packet after reset is arbitrated from port 0.
